// File: rtl/dram_responder.sv
// dram_responder: fixed-latency 64-bit DRAM responder used to exercise pipeline stalls.
// Optional macro DRAM_RESPONDER_FAST_WR_EN lets stores complete one cycle after the request.
module dram_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  dram_rd_ctrl,
  input  logic [2:0]  dram_wr_ctrl,
  input  logic [63:0] dram_addr,
  input  logic [63:0] dram_din,
  output logic [63:0] dram_dout,
  output logic        dram_done,
  output logic        dram_busy,
  output logic        dram_err
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [2:0]    rd_q, wr_q;
  logic [AW+2:0] addr_q;
  logic [63:0]   din_q;
  logic [63:0]   mem [DEPTH];

  logic [2:0]    acc_rd, acc_wr;
  logic [AW+2:0] acc_addr;
  logic [63:0]   acc_din;
  logic [AW-1:0] idx;
  logic [2:0]    lane;
  logic [3:0]    nbytes;
  logic [8:0]    size_mask;
  logic [7:0]    byte_en;
  logic [63:0]   word, shifted, din_shift, load_val, store_word, result;
  logic          illegal, misaligned, acc_err;
  logic          req, fast_wr, finish, mem_we;
  logic          unused_addr_hi;

  // Address bits above the array are ignored, so accesses wrap modulo DEPTH*8.
  assign unused_addr_hi = ^dram_addr[63:AW+3];

  // In IDLE the live inputs describe the access (needed for the one-cycle paths);
  // afterwards only the captured copies are used.
  always_comb begin
    if (state == IDLE) begin
      acc_rd   = dram_rd_ctrl;
      acc_wr   = dram_wr_ctrl;
      acc_addr = dram_addr[AW+2:0];
      acc_din  = dram_din;
    end else begin
      acc_rd   = rd_q;
      acc_wr   = wr_q;
      acc_addr = addr_q;
      acc_din  = din_q;
    end
  end

  assign idx       = acc_addr[AW+2:3];
  assign lane      = acc_addr[2:0];
  assign word      = mem[idx];
  assign shifted   = word >> {lane, 3'b000};
  assign din_shift = acc_din << {lane, 3'b000};

  always_comb begin
    nbytes = 4'd1;
    if (acc_wr != 3'd0) begin
      case (acc_wr)
        3'd2:    nbytes = 4'd2;
        3'd3:    nbytes = 4'd4;
        3'd4:    nbytes = 4'd8;
        default: nbytes = 4'd1;
      endcase
    end else begin
      case (acc_rd)
        3'd3, 3'd4: nbytes = 4'd2;
        3'd5, 3'd6: nbytes = 4'd4;
        3'd7:       nbytes = 4'd8;
        default:    nbytes = 4'd1;
      endcase
    end
  end

  assign illegal    = (acc_wr > 3'd4) || (acc_rd != 3'd0 && acc_wr != 3'd0);
  assign misaligned = (nbytes == 4'd2 && lane[0]) ||
                      (nbytes == 4'd4 && lane[1:0] != 2'd0) ||
                      (nbytes == 4'd8 && lane != 3'd0);
  assign acc_err    = illegal || misaligned;

  always_comb begin
    case (acc_rd)
      3'd1:    load_val = {{56{shifted[7]}}, shifted[7:0]};
      3'd2:    load_val = {56'd0, shifted[7:0]};
      3'd3:    load_val = {{48{shifted[15]}}, shifted[15:0]};
      3'd4:    load_val = {48'd0, shifted[15:0]};
      3'd5:    load_val = {{32{shifted[31]}}, shifted[31:0]};
      3'd6:    load_val = {32'd0, shifted[31:0]};
      3'd7:    load_val = shifted;
      default: load_val = 64'd0;
    endcase
  end

  assign size_mask = (9'd1 << nbytes) - 9'd1;
  assign byte_en   = size_mask[7:0] << lane;

  always_comb begin
    store_word = word;
    for (int i = 0; i < 8; i++) begin
      if (byte_en[i]) store_word[8*i +: 8] = din_shift[8*i +: 8];
    end
  end

  assign result = (acc_err || acc_wr != 3'd0) ? 64'd0 : load_val;
  assign req    = (dram_rd_ctrl != 3'd0) || (dram_wr_ctrl != 3'd0);

`ifdef DRAM_RESPONDER_FAST_WR_EN
  assign fast_wr = (dram_wr_ctrl != 3'd0) && (dram_wr_ctrl <= 3'd4) && (dram_rd_ctrl == 3'd0);
`else
  assign fast_wr = 1'b0;
`endif

  // The counter holds the BUSY cycles still to run, so done lands exactly LATENCY
  // cycles after the request cycle; LATENCY=1 skips BUSY entirely.
  assign finish = (state == IDLE && req && (LATENCY == 1 || fast_wr)) ||
                  (state == BUSY && cnt == 4'd1);
  assign mem_we = reset && finish && acc_wr != 3'd0 && !acc_err;

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= store_word;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rd_q      <= 3'd0;
      wr_q      <= 3'd0;
      addr_q    <= '0;
      din_q     <= 64'd0;
      dram_dout <= 64'd0;
      dram_done <= 1'b0;
      dram_busy <= 1'b0;
      dram_err  <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        rd_q   <= dram_rd_ctrl;
        wr_q   <= dram_wr_ctrl;
        addr_q <= dram_addr[AW+2:0];
        din_q  <= dram_din;
      end
      if (finish) begin
        state     <= DONE;
        dram_done <= 1'b1;
        dram_busy <= 1'b1;
        dram_err  <= acc_err;
        dram_dout <= result;
      end else begin
        case (state)
          IDLE: begin
            if (req) begin
              state     <= BUSY;
              dram_busy <= 1'b1;
              cnt       <= 4'(LATENCY - 1);
            end
          end
          BUSY: cnt <= cnt - 4'd1;
          DONE: begin
            state     <= IDLE;
            dram_done <= 1'b0;
            dram_busy <= 1'b0;
            dram_err  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
